alu_operand_entry: RTL and testbench

- Front-end writer for the lab ALU datapath. It is the user-input side that feeds the ALU whose 6-bit result drives the seven-segment output decoder.
- Steps the user through entering operand A, operand B and the 3-bit instruction from slide switches, using an ENTER key and a BACK key.
- Holds the captured values stable for the ALU and signals when a complete operation is presented.
- Also flags instruction codes that the display treats as invalid.

---
 rtl/alu_operand_entry.sv | 198 +++++++++++++++++++
 tb/tb_alu_operand_entry.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_entry
// Purpose  : User-input front end for the lab ALU. Walks the user through
//            entering operand A, operand B and a 3-bit instruction from the
//            slide switches using ENTER / BACK keys, then holds the values
//            stable for the ALU and flags instruction codes the display
//            treats as invalid (3'b010, 3'b011).
// Ports    : clk, rst        - clock, synchronous active-high reset
//            sw              - raw slide switches (asynchronous)
//            key_enter_n     - raw ENTER key, active-low (asynchronous)
//            key_back_n      - raw BACK key, active-low (asynchronous)
//            A, B, instr     - captured operands / instruction
//            stage           - FSM state (GET_A=0, GET_B=1, GET_OP=2, SHOW=3)
//            start           - one-cycle pulse on each entry into SHOW
//            valid           - high while in SHOW
//            error           - high in SHOW when instr is 3'b010 or 3'b011
// Options  : define ALU_ENTRY_DEBOUNCE_EN to debounce the keys with
//            DEBOUNCE_CYCLES stable cycles; otherwise the keys are only
//            synchronised and DEBOUNCE_CYCLES is unused.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_entry #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             key_enter_n,
  input  logic             key_back_n,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [2:0]       instr,
  output logic [1:0]       stage,
  output logic             start,
  output logic             valid,
  output logic             error
);

  localparam logic [1:0] GET_A  = 2'b00;
  localparam logic [1:0] GET_B  = 2'b01;
  localparam logic [1:0] GET_OP = 2'b10;
  localparam logic [1:0] SHOW   = 2'b11;

  // Key vectors: bit 0 = ENTER, bit 1 = BACK (all active-low levels)
  logic [WIDTH-1:0] sw_s1, sw_s2;
  logic [1:0]       key_s1, key_s2;
  logic [1:0]       key_level;
  logic [1:0]       key_prev;
  logic [1:0]       key_pulse;

  // --------------------------------------------------------------------------
  // Two-flop synchronisers. Keys idle high, switches idle low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      key_s1 <= {key_back_n, key_enter_n};
      key_s2 <= key_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Key level: optional debounce
  // --------------------------------------------------------------------------
`ifdef ALU_ENTRY_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  // The stable level flips on the cycle the counter would reach DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar k = 0; k < 2; k++) begin : g_debounce
    logic [CNT_W-1:0] cnt;
    logic             stable;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt    <= '0;
        stable <= 1'b1;
      end else if (key_s2[k] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= key_s2[k];
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign key_level[k] = stable;
  end
`else
  assign key_level = key_s2;

  logic unused_debounce;
  assign unused_debounce = ^DEBOUNCE_CYCLES;
`endif

  // --------------------------------------------------------------------------
  // Press detection: registered pulse on each 1->0 of the key level.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      key_prev  <= 2'b11;
      key_pulse <= 2'b00;
    end else begin
      key_prev  <= key_level;
      key_pulse <= key_prev & ~key_level;
    end
  end

  // Simultaneous presses cancel each other out.
  logic enter_p, back_p;
  assign enter_p = key_pulse[0] & ~key_pulse[1];
  assign back_p  = key_pulse[1] & ~key_pulse[0];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  logic [1:0] state, next_state;

  always_ff @(posedge clk) begin
    if (rst) state <= GET_A;
    else     state <= next_state;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      GET_A:  if (enter_p) next_state = GET_B;
      GET_B:  if (enter_p) next_state = GET_OP;
              else if (back_p) next_state = GET_A;
      GET_OP: if (enter_p) next_state = SHOW;
              else if (back_p) next_state = GET_B;
      SHOW:   if (enter_p) next_state = GET_A;
              else if (back_p) next_state = GET_OP;
      default: next_state = GET_A;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / capture-enable logic
  // --------------------------------------------------------------------------
  logic load_a, load_b, load_op;

  always_comb begin
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
    valid   = 1'b0;
    case (state)
      GET_A:  load_a  = enter_p;
      GET_B:  load_b  = enter_p;
      GET_OP: load_op = enter_p;
      SHOW:   valid   = 1'b1;
      default: ;
    endcase
  end

  assign stage = state;

  // --------------------------------------------------------------------------
  // Captured values and registered flags
  // --------------------------------------------------------------------------
  logic entering_show;
  assign entering_show = (next_state == SHOW) && (state != SHOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      A     <= '0;
      B     <= '0;
      instr <= '0;
      start <= 1'b0;
      error <= 1'b0;
    end else begin
      if (load_a)  A     <= sw_s2;
      if (load_b)  B     <= sw_s2;
      if (load_op) instr <= sw_s2[2:0];
      start <= entering_show;
      // Only GET_OP enters SHOW, so the code being captured is sw_s2[2:0].
      if (next_state != SHOW)
        error <= 1'b0;
      else if (entering_show)
        error <= (sw_s2[2:1] == 2'b01);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_entry
// Purpose  : Scoreboard bench for alu_operand_entry. Stimulus pushes the
//            expected output tuple for every change it causes; a monitor pops
//            and compares whenever the DUT outputs change. With
//            ALU_ENTRY_DEBOUNCE_EN defined the short-glitch case is added.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_entry;

  localparam int WIDTH = 5;
  localparam int DEB   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw;
  logic             key_enter_n, key_back_n;
  logic [WIDTH-1:0] A, B;
  logic [2:0]       instr;
  logic [1:0]       stage;
  logic             start, valid, error;

  alu_operand_entry #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .key_enter_n(key_enter_n), .key_back_n(key_back_n),
    .A(A), .B(B), .instr(instr), .stage(stage),
    .start(start), .valid(valid), .error(error)
  );

  always #5 clk = ~clk;

  // tuple = {stage, A, B, instr, start, valid, error}
  typedef logic [17:0] tuple_t;
  tuple_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  logic   mon_en = 1'b0;

  task automatic expect_out(input logic [1:0] st, input logic [4:0] a, input logic [4:0] b,
                            input logic [2:0] op, input logic s, input logic v, input logic e);
    exp_q.push_back({st, a, b, op, s, v, e});
  endtask

  // Entering SHOW produces a start=1 tuple followed by a start=0 tuple.
  task automatic expect_show(input logic [4:0] a, input logic [4:0] b,
                             input logic [2:0] op, input logic e);
    expect_out(2'd3, a, b, op, 1'b1, 1'b1, e);
    expect_out(2'd3, a, b, op, 1'b0, 1'b1, e);
  endtask

  // Hold the selected keys low for n cycles, then release and let it settle.
  task automatic press(input bit ent, input bit bak, input int n);
    @(negedge clk);
    key_enter_n = ~ent;
    key_back_n  = ~bak;
    repeat (n) @(negedge clk);
    key_enter_n = 1'b1;
    key_back_n  = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic enter_val(input logic [4:0] v);
    @(negedge clk);
    sw = v;
    press(1'b1, 1'b0, 10);
  endtask

  // Monitor: compare on every change of the observed outputs.
  initial begin : monitor
    tuple_t obs, last, e;
    bit     have_last;
    have_last = 1'b0;
    last      = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        obs = {stage, A, B, instr, start, valid, error};
        if (!have_last || obs !== last) begin
          have_last = 1'b1;
          last      = obs;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event stage=%0d A=%h B=%h instr=%0d start=%b valid=%b error=%b required=none",
                     obs[17:16], obs[15:11], obs[10:6], obs[5:3], obs[2], obs[1], obs[0]);
          end else begin
            e = exp_q.pop_front();
            if (obs !== e)begin
              errors++;
              $display("FAIL event got stage=%0d A=%h B=%h instr=%0d start=%b valid=%b error=%b required stage=%0d A=%h B=%h instr=%0d start=%b valid=%b error=%b",
                       obs[17:16], obs[15:11], obs[10:6], obs[5:3], obs[2], obs[1], obs[0],
                       e[17:16], e[15:11], e[10:6], e[5:3], e[2], e[1], e[0]);
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    rst         = 1'b1;
    sw          = '0;
    key_enter_n = 1'b1;
    key_back_n  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    expect_out(2'd0, 5'h00, 5'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // BACK in GET_A is ignored
    press(1'b0, 1'b1, 10);

    // Full entry
    expect_out(2'd1, 5'h03, 5'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    enter_val(5'b00011);
    expect_out(2'd2, 5'h03, 5'h1E, 3'd0, 1'b0, 1'b0, 1'b0);
    enter_val(5'b11110);
    expect_show(5'h03, 5'h1E, 3'd1, 1'b0);
    enter_val(5'b00001);

    // Navigation: SHOW -BACK-> GET_OP -BACK-> GET_B, re-enter B
    expect_out(2'd2, 5'h03, 5'h1E, 3'd1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 10);
    expect_out(2'd1, 5'h03, 5'h1E, 3'd1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 10);
    expect_out(2'd2, 5'h03, 5'h07, 3'd1, 1'b0, 1'b0, 1'b0);
    enter_val(5'h07);
    expect_show(5'h03, 5'h07, 3'd1, 1'b0);
    enter_val(5'h01);
    expect_out(2'd0, 5'h03, 5'h07, 3'd1, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 10);

    // Invalid instruction 3'b011, BACK clears error, then 3'b010
    expect_out(2'd1, 5'h02, 5'h07, 3'd1, 1'b0, 1'b0, 1'b0);
    enter_val(5'h02);
    expect_out(2'd2, 5'h02, 5'h04, 3'd1, 1'b0, 1'b0, 1'b0);
    enter_val(5'h04);
    expect_show(5'h02, 5'h04, 3'd3, 1'b1);
    enter_val(5'b00011);
    expect_out(2'd2, 5'h02, 5'h04, 3'd3, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 10);
    expect_show(5'h02, 5'h04, 3'd2, 1'b1);
    enter_val(5'b00010);
    expect_out(2'd0, 5'h02, 5'h04, 3'd2, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 10);

`ifdef ALU_ENTRY_DEBOUNCE_EN
    // Glitch shorter than the debounce window: no change
    @(negedge clk);
    sw = 5'h0F;
    press(1'b1, 1'b0, 2);
`endif

    // Long hold: exactly one advance
    expect_out(2'd1, 5'h0F, 5'h04, 3'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    sw = 5'h0F;
    press(1'b1, 1'b0, 100);

    // Simultaneous ENTER + BACK in GET_B: no change
    press(1'b1, 1'b1, 10);

    // Reset mid-entry
    expect_out(2'd0, 5'h00, 5'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Every expected event must have been observed
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events pending=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
